// File: rtl/rs_generic_age_if.sv
// Port bundle for the age-ordered reservation station: dispatch, CDB wakeup,
// branch kill/resolve and issue. The station is the slave side.
interface rs_generic_age_if #(
    parameter int DEPTH     = 4,
    parameter int NUM_CDB   = 2,
    parameter int ROB_W     = 3,
    parameter int BR_W      = 4,
    parameter int PAYLOAD_W = 8
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                     flush;
    logic                     disp_valid;
    logic                     disp_ready;
    logic                     disp_rs1_ready;
    logic                     disp_rs2_ready;
    logic [31:0]              disp_rs1_data;
    logic [31:0]              disp_rs2_data;
    logic [ROB_W-1:0]         disp_rs1_rob;
    logic [ROB_W-1:0]         disp_rs2_rob;
    logic [ROB_W-1:0]         disp_dest_rob;
    logic [BR_W-1:0]          disp_br_mask;
    logic [PAYLOAD_W-1:0]     disp_payload;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob;
    logic [NUM_CDB*32-1:0]    cdb_data;
    logic                     kill_valid;
    logic [BR_W-1:0]          kill_mask;
    logic                     resolve_valid;
    logic [BR_W-1:0]          resolve_mask;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [31:0]              issue_rs1_data;
    logic [31:0]              issue_rs2_data;
    logic [ROB_W-1:0]         issue_dest_rob;
    logic [BR_W-1:0]          issue_br_mask;
    logic [PAYLOAD_W-1:0]     issue_payload;
    logic [OCC_W-1:0]         occupancy;

    modport master (
        output flush, disp_valid, disp_rs1_ready, disp_rs2_ready, disp_rs1_data,
               disp_rs2_data, disp_rs1_rob, disp_rs2_rob, disp_dest_rob,
               disp_br_mask, disp_payload, cdb_valid, cdb_rob, cdb_data,
               kill_valid, kill_mask, resolve_valid, resolve_mask, issue_ready,
        input  disp_ready, issue_valid, issue_rs1_data, issue_rs2_data,
               issue_dest_rob, issue_br_mask, issue_payload, occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_rs1_ready, disp_rs2_ready, disp_rs1_data,
               disp_rs2_data, disp_rs1_rob, disp_rs2_rob, disp_dest_rob,
               disp_br_mask, disp_payload, cdb_valid, cdb_rob, cdb_data,
               kill_valid, kill_mask, resolve_valid, resolve_mask, issue_ready,
        output disp_ready, issue_valid, issue_rs1_data, issue_rs2_data,
               issue_dest_rob, issue_br_mask, issue_payload, occupancy
    );
endinterface

// File: rtl/rs_generic_age.sv
// Generic reservation station: DEPTH entries, NUM_CDB wakeup ports, oldest-ready
// issue through an age matrix, selective squash by speculative branch mask.
module rs_generic_age #(
    parameter int DEPTH     = 4,
    parameter int NUM_CDB   = 2,
    parameter int ROB_W     = 3,
    parameter int BR_W      = 4,
    parameter int PAYLOAD_W = 8
) (
    input logic            clk,
    input logic            rst,
    rs_generic_age_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             ready;
        logic [31:0]      data;
        logic [ROB_W-1:0] rob;
    } opnd_t;

    logic [DEPTH-1:0]     valid_q;
    opnd_t                rs1_q  [DEPTH];
    opnd_t                rs2_q  [DEPTH];
    logic [ROB_W-1:0]     dest_q [DEPTH];
    logic [BR_W-1:0]      mask_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q  [DEPTH];
    logic [DEPTH-1:0]     age_q  [DEPTH];

    logic [DEPTH-1:0] kill_hit;
    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic [OCC_W-1:0] occ;
    logic [BR_W-1:0]  res_clr;
    logic             disp_ready;
    logic             disp_keep;
    logic             issue_valid;
    logic             issue_fire;
    opnd_t            d_rs1;
    opnd_t            d_rs2;

    // Lowest-index CDB port wins when several carry the same tag.
    function automatic opnd_t wake(input opnd_t op,
                                   input logic [NUM_CDB-1:0] cv,
                                   input logic [NUM_CDB*ROB_W-1:0] cr,
                                   input logic [NUM_CDB*32-1:0] cd);
        opnd_t r;
        r = op;
        if (!op.ready) begin
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (cv[p] && (cr[p*ROB_W +: ROB_W] == op.rob)) begin
                    r.ready = 1'b1;
                    r.data  = cd[p*32 +: 32];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        occ      = '0;
        kill_hit = '0;
        eligible = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ         = occ + OCC_W'(valid_q[i]);
            kill_hit[i] = bus.kill_valid && (|(mask_q[i] & bus.kill_mask));
            eligible[i] = valid_q[i] && rs1_q[i].ready && rs2_q[i].ready && !kill_hit[i];
        end
    end

    // An eligible entry is selected when it is older than every other eligible one.
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic oldest;
            oldest = eligible[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && eligible[j] && !age_q[i][j]) oldest = 1'b0;
            end
            if (oldest) begin
                sel_oh[i] = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        logic found;
        found    = 1'b0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !found) begin
                free_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        d_rs1       = '{ready: bus.disp_rs1_ready, data: bus.disp_rs1_data, rob: bus.disp_rs1_rob};
        d_rs2       = '{ready: bus.disp_rs2_ready, data: bus.disp_rs2_data, rob: bus.disp_rs2_rob};
        res_clr     = bus.resolve_valid ? bus.resolve_mask : '0;
        disp_ready  = !rst && (occ != OCC_W'(DEPTH));
        disp_keep   = bus.disp_valid && disp_ready && !bus.flush &&
                      !(bus.kill_valid && (|(bus.disp_br_mask & bus.kill_mask)));
        issue_valid = (|eligible) && !bus.flush && !rst;
        issue_fire  = issue_valid && bus.issue_ready;
    end

    assign bus.disp_ready     = disp_ready;
    assign bus.issue_valid    = issue_valid;
    assign bus.issue_rs1_data = rs1_q[sel_idx].data;
    assign bus.issue_rs2_data = rs2_q[sel_idx].data;
    assign bus.issue_dest_rob = dest_q[sel_idx];
    assign bus.issue_br_mask  = mask_q[sel_idx] & ~res_clr;
    assign bus.issue_payload  = pay_q[sel_idx];
    assign bus.occupancy      = occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i]) begin
                    if (kill_hit[i] || (issue_fire && sel_oh[i])) valid_q[i] <= 1'b0;
                    rs1_q[i]  <= wake(rs1_q[i], bus.cdb_valid, bus.cdb_rob, bus.cdb_data);
                    rs2_q[i]  <= wake(rs2_q[i], bus.cdb_valid, bus.cdb_rob, bus.cdb_data);
                    mask_q[i] <= mask_q[i] & ~res_clr;
                end
            end
            // New entry is younger than everyone; stale column bits are rewritten when those slots refill.
            if (disp_keep) begin
                valid_q[free_idx] <= 1'b1;
                rs1_q[free_idx]   <= wake(d_rs1, bus.cdb_valid, bus.cdb_rob, bus.cdb_data);
                rs2_q[free_idx]   <= wake(d_rs2, bus.cdb_valid, bus.cdb_rob, bus.cdb_data);
                dest_q[free_idx]  <= bus.disp_dest_rob;
                mask_q[free_idx]  <= bus.disp_br_mask & ~res_clr;
                pay_q[free_idx]   <= bus.disp_payload;
                for (int j = 0; j < DEPTH; j++) begin
                    age_q[free_idx][j] <= 1'b0;
                    if (IDX_W'(j) != free_idx) age_q[j][free_idx] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_generic_age.sv
// Bench for rs_generic_age: directed vector table and corner sequences, then
// random traffic against an age-ordered queue model.
module tb_rs_generic_age;
    localparam int DEPTH = 4, NUM_CDB = 2, ROB_W = 3, BR_W = 4, PAYLOAD_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_generic_age_if #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .ROB_W(ROB_W),
                        .BR_W(BR_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    rs_generic_age #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .ROB_W(ROB_W),
                     .BR_W(BR_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       dv;
        logic [7:0] pay;
        logic       ir;
        logic       edr;
        int         eocc;
        logic       eiv;
        logic [7:0] epay;
    } vec_t;
    vec_t tv [9];

    typedef struct {
        logic             r1, r2;
        logic [31:0]      d1, d2;
        logic [ROB_W-1:0] t1, t2, dest;
        logic [BR_W-1:0]  mask;
        logic [PAYLOAD_W-1:0] pay;
    } m_t;
    m_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.flush = 0; bus.disp_valid = 0; bus.disp_rs1_ready = 0; bus.disp_rs2_ready = 0;
        bus.disp_rs1_data = 0; bus.disp_rs2_data = 0; bus.disp_rs1_rob = 0; bus.disp_rs2_rob = 0;
        bus.disp_dest_rob = 0; bus.disp_br_mask = 0; bus.disp_payload = 0;
        bus.cdb_valid = 0; bus.cdb_rob = 0; bus.cdb_data = 0;
        bus.kill_valid = 0; bus.kill_mask = 0; bus.resolve_valid = 0; bus.resolve_mask = 0;
        bus.issue_ready = 0;
    endtask

    task automatic set_disp(input logic v, input logic [7:0] pay, input logic [3:0] mask,
                            input logic r1, input logic [2:0] t1,
                            input logic r2, input logic [2:0] t2);
        bus.disp_valid     = v;
        bus.disp_payload   = pay;
        bus.disp_br_mask   = mask;
        bus.disp_rs1_ready = r1;
        bus.disp_rs1_rob   = t1;
        bus.disp_rs2_ready = r2;
        bus.disp_rs2_rob   = t2;
        bus.disp_rs1_data  = {24'h0, pay};
        bus.disp_rs2_data  = {pay, 24'h0};
        bus.disp_dest_rob  = pay[2:0];
    endtask

    task automatic settle(); #1; endtask
    task automatic tick(); @(posedge clk); #1; endtask

    function automatic m_t wake_e(input m_t e);
        m_t r;
        bit done1, done2;
        r = e; done1 = r.r1; done2 = r.r2;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (bus.cdb_valid[p]) begin
                if (!done1 && bus.cdb_rob[p*ROB_W +: ROB_W] == r.t1) begin
                    r.r1 = 1; r.d1 = bus.cdb_data[p*32 +: 32]; done1 = 1;
                end
                if (!done2 && bus.cdb_rob[p*ROB_W +: ROB_W] == r.t2) begin
                    r.r2 = 1; r.d2 = bus.cdb_data[p*32 +: 32]; done2 = 1;
                end
            end
        end
        return r;
    endfunction

    task automatic rand_cycle();
        int   sel;
        logic edr;
        logic [BR_W-1:0] res;
        m_t   e;
        rst               = ($urandom_range(0, 249) == 0);
        bus.flush         = ($urandom_range(0, 63) == 0);
        bus.disp_valid    = ($urandom_range(0, 1) == 1);
        bus.disp_rs1_ready = ($urandom_range(0, 1) == 1);
        bus.disp_rs2_ready = ($urandom_range(0, 1) == 1);
        bus.disp_rs1_data = $urandom();
        bus.disp_rs2_data = $urandom();
        bus.disp_rs1_rob  = ROB_W'($urandom());
        bus.disp_rs2_rob  = ROB_W'($urandom());
        bus.disp_dest_rob = ROB_W'($urandom());
        bus.disp_br_mask  = ($urandom_range(0, 1) == 1) ? BR_W'($urandom()) : '0;
        bus.disp_payload  = PAYLOAD_W'($urandom());
        bus.cdb_valid     = NUM_CDB'($urandom());
        bus.cdb_rob       = (NUM_CDB*ROB_W)'($urandom());
        bus.cdb_data      = {$urandom(), $urandom()};
        bus.kill_valid    = ($urandom_range(0, 15) == 0);
        bus.kill_mask     = BR_W'($urandom_range(1, (1 << BR_W) - 1));
        bus.resolve_valid = ($urandom_range(0, 7) == 0);
        bus.resolve_mask  = BR_W'($urandom());
        bus.issue_ready   = ($urandom_range(0, 9) < 6);
        settle();

        edr = !rst && (mq.size() < DEPTH);
        res = bus.resolve_valid ? bus.resolve_mask : '0;
        sel = -1;
        if (!rst && !bus.flush) begin
            for (int k = 0; k < mq.size(); k++) begin
                if (mq[k].r1 && mq[k].r2 &&
                    !(bus.kill_valid && ((mq[k].mask & bus.kill_mask) != 0))) begin
                    sel = k;
                    break;
                end
            end
        end
        chk("rnd_disp_ready", 32'(bus.disp_ready), 32'(edr));
        chk("rnd_occupancy", 32'(bus.occupancy), 32'(mq.size()));
        chk("rnd_issue_valid", 32'(bus.issue_valid), 32'(sel >= 0));
        if (sel >= 0) begin
            chk("rnd_rs1_data", bus.issue_rs1_data, mq[sel].d1);
            chk("rnd_rs2_data", bus.issue_rs2_data, mq[sel].d2);
            chk("rnd_dest_rob", 32'(bus.issue_dest_rob), 32'(mq[sel].dest));
            chk("rnd_br_mask", 32'(bus.issue_br_mask), 32'(mq[sel].mask & ~res));
            chk("rnd_payload", 32'(bus.issue_payload), 32'(mq[sel].pay));
        end

        if (rst || bus.flush) begin
            mq.delete();
        end else begin
            if (sel >= 0 && bus.issue_ready) mq.delete(sel);
            if (bus.kill_valid) begin
                for (int k = mq.size() - 1; k >= 0; k--)
                    if ((mq[k].mask & bus.kill_mask) != 0) mq.delete(k);
            end
            foreach (mq[k]) begin
                mq[k] = wake_e(mq[k]);
                mq[k].mask = mq[k].mask & ~res;
            end
            if (bus.disp_valid && edr &&
                !(bus.kill_valid && ((bus.disp_br_mask & bus.kill_mask) != 0))) begin
                e = '{r1: bus.disp_rs1_ready, r2: bus.disp_rs2_ready,
                      d1: bus.disp_rs1_data, d2: bus.disp_rs2_data,
                      t1: bus.disp_rs1_rob, t2: bus.disp_rs2_rob,
                      dest: bus.disp_dest_rob, mask: bus.disp_br_mask & ~res,
                      pay: bus.disp_payload};
                mq.push_back(wake_e(e));
            end
        end
        tick();
    endtask

    initial begin
        //            dv  pay    ir edr occ eiv epay
        tv[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 0, 1'b0, 8'h00};
        tv[1] = '{1'b1, 8'hB2, 1'b0, 1'b1, 1, 1'b1, 8'hA1};
        tv[2] = '{1'b1, 8'hC3, 1'b0, 1'b1, 2, 1'b1, 8'hA1};
        tv[3] = '{1'b1, 8'hD4, 1'b0, 1'b1, 3, 1'b1, 8'hA1};
        tv[4] = '{1'b1, 8'hEE, 1'b1, 1'b0, 4, 1'b1, 8'hA1};
        tv[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 3, 1'b1, 8'hB2};
        tv[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 2, 1'b1, 8'hC3};
        tv[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b1, 8'hD4};
        tv[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00};

        rst = 1'b1;
        clear_inputs();
        settle();
        chk("rst_disp_ready", 32'(bus.disp_ready), 0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 0);
        tick();
        tick();
        rst = 1'b0;

        // Age ordering and full-with-issue
        for (int k = 0; k < 9; k++) begin
            set_disp(tv[k].dv, tv[k].pay, 4'b0000, 1'b1, 3'd0, 1'b1, 3'd0);
            bus.issue_ready = tv[k].ir;
            settle();
            chk("t1_disp_ready", 32'(bus.disp_ready), 32'(tv[k].edr));
            chk("t1_occupancy", 32'(bus.occupancy), 32'(tv[k].eocc));
            chk("t1_issue_valid", 32'(bus.issue_valid), 32'(tv[k].eiv));
            if (tv[k].eiv) chk("t1_payload", 32'(bus.issue_payload), 32'(tv[k].epay));
            tick();
        end

        // Wakeup on CDB port 1; ready younger op goes first
        clear_inputs();
        set_disp(1'b1, 8'h58, 4'b0000, 1'b0, 3'd5, 1'b1, 3'd0);
        tick();
        set_disp(1'b1, 8'h59, 4'b0000, 1'b1, 3'd0, 1'b1, 3'd0);
        settle();
        chk("t2_x_not_ready", 32'(bus.issue_valid), 0);
        tick();
        clear_inputs();
        bus.cdb_valid = 2'b10; bus.cdb_rob = {3'd5, 3'd0}; bus.cdb_data = {32'hDEADBEEF, 32'h0};
        bus.issue_ready = 1'b1;
        settle();
        chk("t2_y_first_valid", 32'(bus.issue_valid), 1);
        chk("t2_y_first", 32'(bus.issue_payload), 32'h59);
        tick();
        bus.cdb_valid = 2'b00;
        settle();
        chk("t2_x_valid", 32'(bus.issue_valid), 1);
        chk("t2_x_payload", 32'(bus.issue_payload), 32'h58);
        chk("t2_x_rs1_data", bus.issue_rs1_data, 32'hDEADBEEF);
        tick();
        bus.issue_ready = 1'b0;
        settle();
        chk("t2_empty", 32'(bus.occupancy), 0);

        // Dispatch/CDB bypass on rs2
        set_disp(1'b1, 8'h33, 4'b0000, 1'b1, 3'd0, 1'b0, 3'd3);
        bus.cdb_valid = 2'b01; bus.cdb_rob = {3'd0, 3'd3}; bus.cdb_data = {32'h0, 32'h1234};
        settle();
        chk("t3_no_bypass_issue", 32'(bus.issue_valid), 0);
        tick();
        clear_inputs();
        bus.issue_ready = 1'b1;
        settle();
        chk("t3_valid", 32'(bus.issue_valid), 1);
        chk("t3_rs2_data", bus.issue_rs2_data, 32'h1234);
        chk("t3_payload", 32'(bus.issue_payload), 32'h33);
        tick();
        bus.issue_ready = 1'b0;

        // Kill then resolve in the same cycle
        set_disp(1'b1, 8'h41, 4'b0001, 1'b1, 3'd0, 1'b1, 3'd0); tick();
        set_disp(1'b1, 8'h42, 4'b0010, 1'b1, 3'd0, 1'b1, 3'd0); tick();
        set_disp(1'b1, 8'h43, 4'b0000, 1'b1, 3'd0, 1'b1, 3'd0); tick();
        clear_inputs();
        bus.kill_valid = 1'b1; bus.kill_mask = 4'b0001;
        bus.resolve_valid = 1'b1; bus.resolve_mask = 4'b0010;
        settle();
        chk("t4_occ_before", 32'(bus.occupancy), 3);
        chk("t4_sel_skips_killed", 32'(bus.issue_payload), 32'h42);
        chk("t4_br_mask_bypass", 32'(bus.issue_br_mask), 0);
        tick();
        clear_inputs();
        bus.issue_ready = 1'b1;
        settle();
        chk("t4_occ_after", 32'(bus.occupancy), 2);
        chk("t4_second_payload", 32'(bus.issue_payload), 32'h42);
        chk("t4_second_mask", 32'(bus.issue_br_mask), 0);
        tick();
        settle();
        chk("t4_third_payload", 32'(bus.issue_payload), 32'h43);
        tick();
        bus.issue_ready = 1'b0;

        // Flush with same-cycle dispatch
        for (int k = 0; k < 3; k++) begin
            set_disp(1'b1, 8'h51 + 8'(k), 4'b0000, 1'b1, 3'd0, 1'b1, 3'd0);
            tick();
        end
        set_disp(1'b1, 8'h5F, 4'b0000, 1'b1, 3'd0, 1'b1, 3'd0);
        bus.flush = 1'b1; bus.issue_ready = 1'b1;
        settle();
        chk("t5_flush_issue_valid", 32'(bus.issue_valid), 0);
        chk("t5_flush_occ_before", 32'(bus.occupancy), 3);
        tick();
        clear_inputs();
        settle();
        chk("t5_occ", 32'(bus.occupancy), 0);
        chk("t5_issue_valid", 32'(bus.issue_valid), 0);
        chk("t5_disp_ready", 32'(bus.disp_ready), 1);

        // Reset mid-operation
        for (int k = 0; k < 2; k++) begin
            set_disp(1'b1, 8'h61 + 8'(k), 4'b0000, 1'b1, 3'd0, 1'b1, 3'd0);
            tick();
        end
        clear_inputs();
        rst = 1'b1; bus.issue_ready = 1'b1;
        settle();
        chk("t6_rst_issue_valid", 32'(bus.issue_valid), 0);
        chk("t6_rst_disp_ready", 32'(bus.disp_ready), 0);
        tick();
        rst = 1'b0;
        settle();
        chk("t6_occ", 32'(bus.occupancy), 0);
        chk("t6_issue_valid", 32'(bus.issue_valid), 0);
        chk("t6_disp_ready", 32'(bus.disp_ready), 1);
        tick();
        settle();
        chk("t6_no_stale_issue", 32'(bus.issue_valid), 0);
        clear_inputs();

        mq.delete();
        for (int n = 0; n < 3000; n++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rs_generic_age.md
Name: rs_generic_age

Overview:
Parametrised reservation station, the successor to the fixed per-unit stations (ALU, MUL, DIV, CMP). It holds DEPTH dispatched ops and wakes operands from NUM_CDB broadcast buses. It issues the oldest ready entry to its functional unit and squashes entries selectively by speculative branch mask. One instance per functional-unit class; the opcode fields travel in an opaque payload.

Parameters:
DEPTH, 4, number of entries (power of 2 not required, >=2)
NUM_CDB, 2, number of CDB wakeup ports
ROB_W, 3, ROB index width
BR_W, 4, branch-mask width (one bit per outstanding unresolved branch)
PAYLOAD_W, 8, opaque per-unit control bits (opcode, mult_type, funct3, ...)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  full squash, all entries invalidated
disp_valid  in  1  dispatch request
disp_ready  out  1  space available
disp_rs1_ready / disp_rs2_ready  in  1 each  operand already valid
disp_rs1_data / disp_rs2_data  in  32 each  operand value when ready
disp_rs1_rob / disp_rs2_rob  in  ROB_W each  producer tag when not ready
disp_dest_rob  in  ROB_W  destination ROB index
disp_br_mask  in  BR_W  branches this op depends on
disp_payload  in  PAYLOAD_W  unit control
cdb_valid  in  NUM_CDB  per-port broadcast valid
cdb_rob  in  NUM_CDB*ROB_W  per-port ROB tag, port i at [i*ROB_W +: ROB_W]
cdb_data  in  NUM_CDB*32  per-port value
kill_valid  in  1  mispredict squash
kill_mask  in  BR_W  squash entries whose br_mask overlaps this mask
resolve_valid  in  1  correct-prediction resolve
resolve_mask  in  BR_W  bits to clear from all entry masks
issue_valid  out  1  selected entry is ready
issue_ready  in  1  functional unit accepts
issue_rs1_data / issue_rs2_data  out  32 each
issue_dest_rob  out  ROB_W
issue_br_mask  out  BR_W  mask after same-cycle resolve clearing
issue_payload  out  PAYLOAD_W
occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Entry state: valid, two {ready, data, rob} operands, dest_rob, br_mask, payload. DEPTH x DEPTH age matrix: age[i][j]=1 means i is older than j.
- Reset: all entries invalid, age matrix cleared. occupancy=0 and issue_valid=0. disp_ready=0 while rst is high and 1 in the first cycle after reset.
- disp_ready = (occupancy < DEPTH). It is computed from registered state only and does not credit a same-cycle issue.
- Dispatch fires on disp_valid & disp_ready. The op is written into the lowest-index free entry and becomes older-than-nobody and younger than all valid entries.
- Dispatch/CDB same-cycle bypass: a not-ready dispatch operand whose rob matches a valid CDB port that cycle is stored ready with that CDB's data.
- Wakeup: every valid, not-ready operand compares against all NUM_CDB ports each cycle. On a match it captures data and sets ready at the edge. If multiple ports match, the lowest port index wins.
- Issue select (combinational from registered state): eligible = valid & rs1.ready & rs2.ready & no kill hit this cycle. The oldest eligible entry is selected via the age matrix, and issue_* fields show that entry.
- An entry woken in cycle N is first eligible in cycle N+1 (no CDB-to-issue bypass). issue_valid=0 when nothing is eligible, and the data outputs are then don't-care.
- Issue handshake: issue_valid & issue_ready frees the selected entry at the edge. Outputs may change while issue_ready=0; selection is recomputed each cycle, so an older entry becoming ready preempts.
- Kill: when kill_valid, every entry with (br_mask & kill_mask) != 0 is invalidated at the edge. A dispatch in the same cycle whose disp_br_mask overlaps kill_mask is accepted but discarded.
- Resolve: when resolve_valid, br_mask &= ~resolve_mask in all surviving entries and in a same-cycle dispatch. issue_br_mask reflects the cleared value.
- kill_valid and resolve_valid on the same cycle: kill is applied first, then resolve clears bits in survivors.
- Priority: rst > flush > kill > issue/dispatch/wakeup. flush invalidates everything, including a same-cycle dispatch, and forces issue_valid=0 that cycle.
- Full with simultaneous issue: no dispatch that cycle; disp_ready rises the next cycle.
- occupancy is updated with the net of dispatch (not discarded), issue, and kills.

Test Plan:
- Reset, then dispatch 4 ready ops A,B,C,D (DEPTH=4) with issue_ready=0 -> disp_ready=0 after the 4th, occupancy=4. Raise issue_ready -> issue order A,B,C,D, one per cycle.
- Dispatch X with rs1 waiting on ROB 5, then Y fully ready; broadcast cdb_rob=5, data=0xDEADBEEF on port 1 -> Y issues first. X issues the cycle after the broadcast, with issue_rs1_data=0xDEADBEEF.
- Dispatch with rs2 waiting on ROB 3 while CDB port 0 carries ROB 3, data=0x1234 the same cycle -> entry eligible next cycle, issue_rs2_data=0x1234.
- Entries with br_mask 0001, 0010, 0000; kill_valid with kill_mask=0001 plus resolve_valid with mask=0010 the same cycle -> first entry is removed and occupancy=2. The second entry issues with issue_br_mask=0000.
- Flush with 3 valid entries plus a same-cycle dispatch -> occupancy=0 next cycle, issue_valid=0, disp_ready=1.
- Assert rst mid-operation with 2 entries pending -> next cycle occupancy=0, issue_valid=0, no stale issue after rst falls.
